// File: rtl/opto_emit_pulse_gen.sv
// Laser emission stage: arms the TDC, fires the laser on angle sync and tags each point with its slot index.
// Optional ARM watchdog is enabled by defining OPTO_ARM_WATCHDOG_EN.
module opto_emit_pulse_gen #(
    parameter int unsigned PULSE_CLKS  = 4,
    parameter int unsigned IDX_W       = 16,
    parameter int unsigned ARM_TIMEOUT = 200
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_emit_en,
    input  logic             i_tdc_strdy,
    input  logic             i_angle_sync,
    input  logic             i_zero_index,
    output logic             o_laser_trig,
    output logic             o_tdc_en,
    output logic             o_tdc_start,
    output logic             o_point_valid,
    output logic [IDX_W-1:0] o_point_idx,
    output logic [IDX_W-1:0] o_rev_points,
    output logic             o_miss,
    output logic             o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_DONE
    } state_t;

    if (PULSE_CLKS < 1 || PULSE_CLKS > 255 || ARM_TIMEOUT < 1) begin : g_bad_cfg
        $error("opto_emit_pulse_gen: PULSE_CLKS must be 1..255 and ARM_TIMEOUT at least 1");
    end

    state_t           r_state;
    logic [7:0]       r_pulse_cnt;
    logic [IDX_W-1:0] r_slot_cnt;
    logic [IDX_W-1:0] r_fire_idx;
    logic             r_laser_trig;
    logic             r_tdc_en;
    logic             r_tdc_start;
    logic             r_point_valid;
    logic [IDX_W-1:0] r_point_idx;
    logic [IDX_W-1:0] r_rev_points;
    logic             r_miss;
    logic             r_overrun;

    logic             w_sync_cnt;
    logic [IDX_W-1:0] w_slot_next;
    logic [IDX_W-1:0] w_cur_idx;
    logic             w_wd_expire;

    assign w_sync_cnt = i_angle_sync & i_emit_en;
    // A zero index coincident with a sync gives that sync slot 0.
    assign w_cur_idx  = i_zero_index ? '0 : r_slot_cnt;

    always_comb begin
        w_slot_next = r_slot_cnt;
        if (i_zero_index) begin
            w_slot_next = w_sync_cnt ? IDX_W'(1) : '0;
        end else if (w_sync_cnt && !(&r_slot_cnt)) begin
            w_slot_next = r_slot_cnt + IDX_W'(1);
        end
    end

`ifdef OPTO_ARM_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(ARM_TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;

    // Held at zero outside ARM so every entry into ARM starts a fresh count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_ARM) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign w_wd_expire = (r_state == S_ARM) && (r_wd_cnt == WD_W'(ARM_TIMEOUT - 1));
`else
    assign w_wd_expire = 1'b0;
`endif

    // NOTE: all state and outputs update with <= so every branch sees the pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_pulse_cnt   <= '0;
            r_slot_cnt    <= '0;
            r_fire_idx    <= '0;
            r_laser_trig  <= 1'b0;
            r_tdc_en      <= 1'b0;
            r_tdc_start   <= 1'b0;
            r_point_valid <= 1'b0;
            r_point_idx   <= '0;
            r_rev_points  <= '0;
            r_miss        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_tdc_start   <= 1'b0;
            r_point_valid <= 1'b0;
            r_miss        <= 1'b0;
            r_overrun     <= 1'b0;
            r_slot_cnt    <= w_slot_next;
            if (i_zero_index) begin
                r_rev_points <= r_slot_cnt;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (i_angle_sync) begin
                        r_miss <= 1'b1;
                    end
                    if (i_emit_en && i_tdc_strdy) begin
                        r_state  <= S_ARM;
                        r_tdc_en <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (!i_emit_en) begin
                        r_state  <= S_IDLE;
                        r_tdc_en <= 1'b0;
                    end else if (i_angle_sync) begin
                        r_state      <= S_FIRE;
                        r_laser_trig <= 1'b1;
                        r_tdc_start  <= 1'b1;
                        r_fire_idx   <= w_cur_idx;
                        r_pulse_cnt  <= 8'(PULSE_CLKS - 1);
                    end else if (w_wd_expire) begin
                        r_state  <= S_IDLE;
                        r_tdc_en <= 1'b0;
                        r_miss   <= 1'b1;
                    end
                end
                S_FIRE: begin
                    if (i_angle_sync) begin
                        r_overrun <= 1'b1;
                    end
                    if (!i_emit_en) begin
                        r_state      <= S_IDLE;
                        r_laser_trig <= 1'b0;
                        r_tdc_en     <= 1'b0;
                    end else if (r_pulse_cnt == 8'd0) begin
                        r_state       <= S_DONE;
                        r_laser_trig  <= 1'b0;
                        r_tdc_en      <= 1'b0;
                        r_point_valid <= 1'b1;
                        r_point_idx   <= r_fire_idx;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    if (i_angle_sync) begin
                        r_overrun <= 1'b1;
                    end
                    if (i_emit_en && i_tdc_strdy) begin
                        r_state  <= S_ARM;
                        r_tdc_en <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_laser_trig  = r_laser_trig;
    assign o_tdc_en      = r_tdc_en;
    assign o_tdc_start   = r_tdc_start;
    assign o_point_valid = r_point_valid;
    assign o_point_idx   = r_point_idx;
    assign o_rev_points  = r_rev_points;
    assign o_miss        = r_miss;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_opto_emit_pulse_gen.sv
// Directed self-checking bench for opto_emit_pulse_gen; inputs change 1ns after posedge and outputs are sampled there.
module tb_opto_emit_pulse_gen;

    localparam int unsigned PULSE_CLKS  = 4;
    localparam int unsigned IDX_W       = 16;
    localparam int unsigned ARM_TIMEOUT = 200;
    localparam int unsigned LEAD        = 10;
    localparam int unsigned PERIOD      = 125;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_emit_en = 1'b0;
    logic             i_tdc_strdy = 1'b0;
    logic             i_angle_sync = 1'b0;
    logic             i_zero_index = 1'b0;
    logic             o_laser_trig;
    logic             o_tdc_en;
    logic             o_tdc_start;
    logic             o_point_valid;
    logic [IDX_W-1:0] o_point_idx;
    logic [IDX_W-1:0] o_rev_points;
    logic             o_miss;
    logic             o_overrun;

    int n_checks = 0;
    int n_errors = 0;

    opto_emit_pulse_gen #(
        .PULSE_CLKS (PULSE_CLKS),
        .IDX_W      (IDX_W),
        .ARM_TIMEOUT(ARM_TIMEOUT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_emit_en    (i_emit_en),
        .i_tdc_strdy  (i_tdc_strdy),
        .i_angle_sync (i_angle_sync),
        .i_zero_index (i_zero_index),
        .o_laser_trig (o_laser_trig),
        .o_tdc_en     (o_tdc_en),
        .o_tdc_start  (o_tdc_start),
        .o_point_valid(o_point_valid),
        .o_point_idx  (o_point_idx),
        .o_rev_points (o_rev_points),
        .o_miss       (o_miss),
        .o_overrun    (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Arm at cycle 0, sync at cycle LEAD, expect a full point with the given index.
    task automatic emit_point(input int unsigned exp_idx, input bit with_zi, input string tag);
        i_tdc_strdy = 1'b1;
        tick();
        i_tdc_strdy = 1'b0;
        check({tag, "_arm_tdc_en"}, o_tdc_en, 1);
        repeat (LEAD - 1) tick();
        i_angle_sync = 1'b1;
        i_zero_index = with_zi;
        tick();
        i_angle_sync = 1'b0;
        i_zero_index = 1'b0;
        check({tag, "_laser"}, o_laser_trig, 1);
        check({tag, "_start"}, o_tdc_start, 1);
        repeat (PULSE_CLKS) tick();
        check({tag, "_valid"}, o_point_valid, 1);
        check({tag, "_idx"}, o_point_idx, exp_idx);
        check({tag, "_done_laser"}, o_laser_trig, 0);
        check({tag, "_done_tdc_en"}, o_tdc_en, 0);
        tick();
        check({tag, "_valid_clr"}, o_point_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        #2;
        check("rst_laser", o_laser_trig, 0);
        check("rst_tdc_en", o_tdc_en, 0);
        check("rst_valid", o_point_valid, 0);
        check("rst_rev", o_rev_points, 0);
        check("rst_miss", o_miss, 0);
        #20;
        i_rst     = 1'b0;
        i_emit_en = 1'b1;
        tick();

        // Nominal point: strdy cycle 0, sync cycle 10.
        i_tdc_strdy = 1'b1;
        tick();
        i_tdc_strdy = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            i_angle_sync = (c == 10);
            check($sformatf("nom_tdc_en_c%0d", c), o_tdc_en, (c <= 14));
            check($sformatf("nom_laser_c%0d", c), o_laser_trig, (c >= 11 && c <= 14));
            check($sformatf("nom_start_c%0d", c), o_tdc_start, (c == 11));
            check($sformatf("nom_valid_c%0d", c), o_point_valid, (c == 15));
            check($sformatf("nom_miss_c%0d", c), o_miss | o_overrun, 0);
            if (c == 15) check("nom_idx", o_point_idx, 0);
            tick();
        end
        i_angle_sync = 1'b0;

        // Periodic stream after a zero index.
        i_zero_index = 1'b1;
        tick();
        i_zero_index = 1'b0;
        check("per_rev_first", o_rev_points, 1);
        for (int k = 0; k < 5; k++) begin
            emit_point(k, 1'b0, $sformatf("per%0d", k));
            repeat (PERIOD - LEAD - 6) tick();
        end
        i_zero_index = 1'b1;
        tick();
        i_zero_index = 1'b0;
        check("per_rev_points", o_rev_points, 5);

        // Missing arm: sync in IDLE still consumes a slot.
        i_angle_sync = 1'b1;
        tick();
        i_angle_sync = 1'b0;
        check("miss_pulse", o_miss, 1);
        check("miss_laser", o_laser_trig, 0);
        tick();
        check("miss_clr", o_miss, 0);
        emit_point(1, 1'b0, "after_miss");

        // Overrun: second sync in FIRE cycle 2.
        i_tdc_strdy = 1'b1;
        tick();
        i_tdc_strdy = 1'b0;
        repeat (LEAD - 1) tick();
        i_angle_sync = 1'b1;
        tick();
        i_angle_sync = 1'b0;
        check("ovr_start", o_tdc_start, 1);
        tick();
        i_angle_sync = 1'b1;
        tick();
        i_angle_sync = 1'b0;
        check("ovr_pulse", o_overrun, 1);
        check("ovr_laser", o_laser_trig, 1);
        tick();
        check("ovr_clr", o_overrun, 0);
        tick();
        check("ovr_valid", o_point_valid, 1);
        check("ovr_idx", o_point_idx, 2);
        tick();
        emit_point(4, 1'b0, "after_ovr");

        // Zero index coincident with sync after 7 slots.
        i_zero_index = 1'b1;
        tick();
        i_zero_index = 1'b0;
        check("zi_rev_5", o_rev_points, 5);
        repeat (7) begin
            i_angle_sync = 1'b1;
            tick();
            i_angle_sync = 1'b0;
            tick();
        end
        emit_point(0, 1'b1, "zi_sync");
        check("zi_rev_7", o_rev_points, 7);
        emit_point(1, 1'b0, "zi_next");

        // Abort: emit_en drops in FIRE cycle 2.
        i_tdc_strdy = 1'b1;
        tick();
        i_tdc_strdy = 1'b0;
        repeat (LEAD - 1) tick();
        i_angle_sync = 1'b1;
        tick();
        i_angle_sync = 1'b0;
        tick();
        check("abort_laser_on", o_laser_trig, 1);
        i_emit_en = 1'b0;
        tick();
        check("abort_laser_off", o_laser_trig, 0);
        check("abort_tdc_en", o_tdc_en, 0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("abort_no_valid%0d", c), o_point_valid, 0);
            tick();
        end
        i_emit_en = 1'b1;

        // Reset mid-FIRE drops the laser without a clock edge.
        i_tdc_strdy = 1'b1;
        tick();
        i_tdc_strdy = 1'b0;
        repeat (LEAD - 1) tick();
        i_angle_sync = 1'b1;
        tick();
        i_angle_sync = 1'b0;
        check("rstfire_laser_on", o_laser_trig, 1);
        #2;
        i_rst = 1'b1;
        #1;
        check("rstfire_laser_async", o_laser_trig, 0);
        check("rstfire_tdc_en", o_tdc_en, 0);
        #2;
        i_rst = 1'b0;
        tick();
        check("rstfire_rev", o_rev_points, 0);
        emit_point(0, 1'b0, "after_rst");

        // Long ARM hold: watchdog abort, or indefinite ARM without it.
        i_tdc_strdy = 1'b1;
        tick();
        i_tdc_strdy = 1'b0;
        repeat (ARM_TIMEOUT - 1) tick();
        check("hold_tdc_en_200", o_tdc_en, 1);
        check("hold_miss_200", o_miss, 0);
        tick();
`ifdef OPTO_ARM_WATCHDOG_EN
        check("wd_tdc_en", o_tdc_en, 0);
        check("wd_miss", o_miss, 1);
        tick();
        check("wd_miss_clr", o_miss, 0);
`else
        check("hold_tdc_en_201", o_tdc_en, 1);
        check("hold_miss_201", o_miss, 0);
        repeat (50) tick();
        check("hold_tdc_en_251", o_tdc_en, 1);
        i_emit_en = 1'b0;
        tick();
        check("hold_exit_tdc_en", o_tdc_en, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
